// File: rtl/reg_row_pkg.sv
// Shared types for the segmented row register: op codes, FSM states, default widths.
package reg_row_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_AND  = 3'd1,
    OP_XOR  = 3'd2,
    OP_OR   = 3'd3,
    OP_SUB  = 3'd4,
    OP_PASS = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_SAT  = 2'd3
  } state_t;

  localparam int DEF_N     = 32;
  localparam int DEF_SEG_W = 8;

endpackage

// File: rtl/seg_alu.sv
// One SEG_W-wide slice of the row ALU; SUB inverts b and relies on cin=1 from the caller.
module seg_alu
  import reg_row_pkg::*;
#(
  parameter int W = DEF_SEG_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic [2:0]   op,
  output logic [W-1:0] res,
  output logic         cout
);

  logic [W:0] sum;

  always_comb begin
    sum  = '0;
    res  = a;
    cout = 1'b0;
    case (op)
      OP_ADD: begin
        sum  = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        res  = sum[W-1:0];
        cout = sum[W];
      end
      OP_SUB: begin
        sum  = {1'b0, a} + {1'b0, ~b} + (W+1)'(cin);
        res  = sum[W-1:0];
        cout = sum[W];
      end
      OP_AND:  res = a & b;
      OP_XOR:  res = a ^ b;
      OP_OR:   res = a | b;
      OP_PASS: res = b;
      // codes 6 and 7 keep the row segment as it is
      default: res = a;
    endcase
  end

endmodule

// File: rtl/reg_row_seg.sv
// Segmented row register with a multi-cycle row ALU, one SEG_W slice per cycle.
// Optional macro ROW_SAT_EN: saturate ADD overflow to all-ones and SUB borrow to all-zeros.
module reg_row_seg
  import reg_row_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] wr_in_up,
  input  logic [N-1:0] wr_in_dn,
  input  logic         wr_sel_up,
  input  logic         wr_sel_dn,
  input  logic         wr_en,
  input  logic         rd_sel_up,
  input  logic         rd_sel_dn,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [2:0]   op_code,
  input  logic         op_src_dn,
  input  logic         first_carry,
  output logic         busy,
  output logic         done,
  output logic         overflow,
  output logic [N-1:0] rd_out_up,
  output logic [N-1:0] rd_out_dn,
  output logic [N-1:0] debug_row_reg
);

  localparam int NSEG   = N / SEG_W;
  localparam int SEG_CW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [SEG_CW-1:0] LAST_SEG = SEG_CW'(NSEG - 1);

  if ((N % SEG_W) != 0 || N < SEG_W) begin : g_bad_width
    $error("reg_row_seg: N must be a non-zero multiple of SEG_W");
  end

  state_t              state;
  logic [N-1:0]        row_q;
  logic [N-1:0]        opnd_q;
  logic [SEG_CW-1:0]   seg_cnt;
  logic [2:0]          op_q;
  logic                carry_q;
  logic                overflow_q;
  logic                done_q;

  logic [SEG_W-1:0]    a_seg;
  logic [SEG_W-1:0]    b_seg;
  logic [SEG_W-1:0]    alu_res;
  logic                alu_cout;
  logic                fin_ovf;

  always_comb begin
    a_seg = row_q[seg_cnt*SEG_W +: SEG_W];
    b_seg = opnd_q[seg_cnt*SEG_W +: SEG_W];
  end

  seg_alu #(.W(SEG_W)) u_seg_alu (
    .a    (a_seg),
    .b    (b_seg),
    .cin  (carry_q),
    .op   (op_q),
    .res  (alu_res),
    .cout (alu_cout)
  );

  // SUB reports borrow, which is the inverse of the final carry of a + ~b + 1
  always_comb begin
    fin_ovf = 1'b0;
    if (op_q == OP_ADD)      fin_ovf = alu_cout;
    else if (op_q == OP_SUB) fin_ovf = ~alu_cout;
  end

  // Handshake: an op transfers on a rising edge where op_valid && op_ready;
  // op_ready is high only in IDLE and the requester may hold op_valid until it does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      row_q      <= '0;
      opnd_q     <= '0;
      seg_cnt    <= '0;
      op_q       <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (op_valid) begin
            opnd_q     <= op_src_dn ? wr_in_dn : wr_in_up;
            op_q       <= op_code;
            carry_q    <= (op_code == OP_ADD) ? first_carry : (op_code == OP_SUB);
            overflow_q <= 1'b0;
            seg_cnt    <= '0;
            state      <= ST_RUN;
          end else if (wr_en) begin
            if (wr_sel_up)      row_q <= wr_in_up;
            else if (wr_sel_dn) row_q <= wr_in_dn;
          end
        end
        ST_RUN: begin
          row_q[seg_cnt*SEG_W +: SEG_W] <= alu_res;
          carry_q <= alu_cout;
          seg_cnt <= seg_cnt + 1'b1;
          if (seg_cnt == LAST_SEG) begin
            seg_cnt    <= '0;
            overflow_q <= fin_ovf;
`ifdef ROW_SAT_EN
            if (fin_ovf) begin
              state <= ST_SAT;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
`else
            state  <= ST_DONE;
            done_q <= 1'b1;
`endif
          end
        end
        ST_SAT: begin
          row_q  <= (op_q == OP_SUB) ? '0 : '1;
          state  <= ST_DONE;
          done_q <= 1'b1;
        end
        ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign op_ready      = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign done          = done_q;
  assign overflow      = overflow_q;
  assign rd_out_up     = rd_sel_up ? row_q : '0;
  assign rd_out_dn     = rd_sel_dn ? row_q : '0;
  assign debug_row_reg = row_q;

endmodule
